hazard_ctrl: RTL and testbench

Hazard and stall controller for the five-stage pipeline. It keeps a shadow scoreboard of the E, M and W stages: destination register, remaining Tnew, and the consumer's Tuse codes. Each cycle it compares the D-stage Tuse demand against that scoreboard and drives the F/D stall, the E-stage bubble insertion, and every forwarding-mux select. It also sequences the multiply/divide unit's busy window, so HI/LO consumers stall until the result is ready.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_if.sv | 17 +
 rtl/hazard_match.sv | 25 ++
 rtl/hazard_ctrl.sv | 48 ++++
 tb/tb_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants, scoreboard entry type and helpers for the hazard controller
package hazard_pkg;
  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] TNEW_NONE = 2'd3;
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E = 2'd1;
  localparam logic [1:0] FWD_M = 2'd2;
  localparam logic [1:0] FWD_W = 2'd3;
  typedef struct packed {
    logic       valid;
    logic [4:0] wa;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
  } sb_entry_t;
  function automatic logic hit(sb_entry_t x, logic [4:0] r);
    return x.valid && x.wa == r && r != 5'd0 && x.tnew != TNEW_NONE;
  endfunction
  function automatic sb_entry_t age(sb_entry_t x);
    sb_entry_t y;
    y = x;
    y.tnew = (x.tnew == TNEW_NONE || x.tnew == 2'd0) ? x.tnew : x.tnew - 2'd1;
    return y;
  endfunction
endpackage

// File: rtl/hazard_if.sv
// hazard_if: D/E-stage hazard request signals and controller responses
interface hazard_if;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_use, e_md_start, e_md_div;
  logic       stall;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic       fwd_rt_m, md_busy;
  modport master (
    output d_rs, d_rt, d_wa, d_tuse_rs, d_tuse_rt, d_tnew, d_md_use, e_md_start, e_md_div,
    input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
  );
  modport slave (
    input  d_rs, d_rt, d_wa, d_tuse_rs, d_tuse_rt, d_tnew, d_md_use, e_md_start, e_md_div,
    output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
  );
endinterface

// File: rtl/hazard_match.sv
// hazard_match: one operand against the E/M/W scoreboard, giving stall need and forwarding source
module hazard_match
  import hazard_pkg::*;
(
  input  logic [4:0] r,
  input  logic [1:0] tuse,
  input  sb_entry_t  e,
  input  sb_entry_t  m,
  input  sb_entry_t  w,
  output logic       stall,
  output logic [1:0] fwd
);
  logic he, hm, hw, unused_bits;
  always_comb begin
    he = hit(e, r);
    hm = hit(m, r);
    hw = hit(w, r);
    stall = tuse != TUSE_NONE && ((he && e.tnew > tuse) || (hm && m.tnew > tuse));
    fwd = he ? (e.tnew == 2'd0 ? FWD_E : FWD_RF) :
          hm ? (m.tnew == 2'd0 ? FWD_M : FWD_RF) :
          hw ? (w.tnew == 2'd0 ? FWD_W : FWD_RF) : FWD_RF;
  end
  assign unused_bits = ^{e.rs, e.rt, e.tuse_rs, e.tuse_rt, m.rs, m.rt, m.tuse_rs, m.tuse_rt,
                         w.rs, w.rt, w.tuse_rs, w.tuse_rt};
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-driven stall, bubble and forwarding control with mult/div busy window
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic     clk,
  input logic     rst_n,
  hazard_if.slave hz
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  localparam sb_entry_t BUBBLE = '0;
  sb_entry_t e_q, m_q, w_q, d_ent;
  logic [CW-1:0] md_cnt;
  logic run, st_rs, st_rt, md_busy, unused_st_rs_e, unused_st_rt_e;
  always_comb begin
    d_ent = '{valid: 1'b1, wa: hz.d_wa, tnew: hz.d_tnew, rs: hz.d_rs, rt: hz.d_rt,
              tuse_rs: hz.d_tuse_rs, tuse_rt: hz.d_tuse_rt};
    md_busy = md_cnt != '0;
  end
  assign hz.md_busy = md_busy;
  assign hz.stall = run && (st_rs || st_rt || (hz.d_md_use && (md_busy || hz.e_md_start)));
  assign hz.fwd_rt_m = m_q.valid && hit(w_q, m_q.rt) && !(m_q.wa == m_q.rt && m_q.tnew != TNEW_NONE);
  hazard_match u_rs_d (.r(hz.d_rs), .tuse(hz.d_tuse_rs), .e(e_q), .m(m_q), .w(w_q),
                       .stall(st_rs), .fwd(hz.fwd_rs_d));
  hazard_match u_rt_d (.r(hz.d_rt), .tuse(hz.d_tuse_rt), .e(e_q), .m(m_q), .w(w_q),
                       .stall(st_rt), .fwd(hz.fwd_rt_d));
  hazard_match u_rs_e (.r(e_q.rs), .tuse(e_q.tuse_rs), .e(BUBBLE), .m(m_q), .w(w_q),
                       .stall(unused_st_rs_e), .fwd(hz.fwd_rs_e));
  hazard_match u_rt_e (.r(e_q.rt), .tuse(e_q.tuse_rt), .e(BUBBLE), .m(m_q), .w(w_q),
                       .stall(unused_st_rt_e), .fwd(hz.fwd_rt_e));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      e_q <= BUBBLE;
      m_q <= BUBBLE;
      w_q <= BUBBLE;
      md_cnt <= '0;
      run <= 1'b0;
    end else begin
      run <= 1'b1;
      e_q <= hz.stall ? BUBBLE : d_ent;
      m_q <= age(e_q);
      w_q <= age(m_q);
      md_cnt <= hz.e_md_start ? (hz.e_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)) :
                md_cnt - CW'(md_busy);
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed pipeline scenarios plus random traffic against an instruction-level model
module tb_hazard_ctrl;
  import hazard_pkg::*;
  localparam int MULT_N = 5;
  localparam int DIV_N = 10;
  typedef struct {bit v; int wa; int tnew; int rs; int rt;} ins_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int md_ready = 0;
  bit live = 0;
  ins_t pipe [3];
  hazard_if hz ();
  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit writes(int k, int r);
    return pipe[k].v && pipe[k].wa == r && r != 0 && pipe[k].tnew != 3;
  endfunction
  function automatic int rem(int k);
    int t;
    t = pipe[k].tnew;
    return t == 3 ? 3 : (t > k ? t - k : 0);
  endfunction
  function automatic bit waits(int r, int tu);
    if (tu == 3) return 0;
    for (int k = 0; k < 2; k++) if (writes(k, r) && rem(k) > tu) return 1;
    return 0;
  endfunction
  function automatic int src(int r, int first);
    for (int k = first; k < 3; k++) if (writes(k, r)) return rem(k) == 0 ? k + 1 : 0;
    return 0;
  endfunction
  function automatic bit exp_stall();
    return live && (waits(int'(hz.d_rs), int'(hz.d_tuse_rs)) || waits(int'(hz.d_rt), int'(hz.d_tuse_rt)) ||
                    (hz.d_md_use && (cyc < md_ready || hz.e_md_start)));
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0, 0};
    md_ready = 0;
    live = 0;
  endtask
  task automatic step();
    bit st;
    if (!rst_n) begin
      model_reset();
      return;
    end
    st = exp_stall();
    cyc++;
    if (hz.e_md_start) md_ready = cyc + (hz.e_md_div ? DIV_N : MULT_N);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = st ? '{0, 0, 0, 0, 0} : '{1, int'(hz.d_wa), int'(hz.d_tnew), int'(hz.d_rs), int'(hz.d_rt)};
    live = 1;
  endtask
  task automatic sample();
    @(negedge clk);
    check("stall", hz.stall, exp_stall());
    check("fwd_rs_d", hz.fwd_rs_d, src(int'(hz.d_rs), 0));
    check("fwd_rt_d", hz.fwd_rt_d, src(int'(hz.d_rt), 0));
    check("fwd_rs_e", hz.fwd_rs_e, pipe[0].v ? src(pipe[0].rs, 1) : 0);
    check("fwd_rt_e", hz.fwd_rt_e, pipe[0].v ? src(pipe[0].rt, 1) : 0);
    check("fwd_rt_m", hz.fwd_rt_m, pipe[1].v && writes(2, pipe[1].rt) &&
                                   !(pipe[1].wa == pipe[1].rt && pipe[1].tnew != 3));
    check("md_busy", hz.md_busy, cyc < md_ready);
  endtask
  task automatic adv();
    @(posedge clk);
    step();
    #1;
  endtask
  task automatic set_d(input int rs, input int rt, input int tr, input int tt, input int wa,
                       input int tn, input int mu);
    hz.d_rs = 5'(rs);
    hz.d_rt = 5'(rt);
    hz.d_tuse_rs = 2'(tr);
    hz.d_tuse_rt = 2'(tt);
    hz.d_wa = 5'(wa);
    hz.d_tnew = 2'(tn);
    hz.d_md_use = 1'(mu);
  endtask
  task automatic set_md(input int s, input int d);
    hz.e_md_start = 1'(s);
    hz.e_md_div = 1'(d);
  endtask
  task automatic nops(input int n);
    set_d(0, 0, 3, 3, 0, 3, 0);
    repeat (n) begin
      sample();
      adv();
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    set_d(0, 0, 3, 3, 0, 3, 0);
    set_md(0, 0);
    model_reset();
    sample();
    #2 rst_n = 1'b1;
    adv();
    nops(3);
    set_d(0, 0, 1, 3, 1, 2, 0);
    sample();
    adv();
    set_d(1, 3, 1, 1, 2, 1, 0);
    sample();
    check("lw_alu_stall", hz.stall, 1);
    adv();
    sample();
    check("lw_alu_release", hz.stall, 0);
    adv();
    set_d(0, 0, 3, 3, 0, 3, 0);
    sample();
    check("lw_alu_fwd_e", hz.fwd_rs_e, 3);
    adv();
    nops(3);
    set_d(0, 0, 1, 3, 1, 2, 0);
    sample();
    adv();
    set_d(1, 0, 0, 0, 0, 3, 0);
    repeat (2) begin
      sample();
      check("lw_br_stall", hz.stall, 1);
      adv();
    end
    sample();
    check("lw_br_release", hz.stall, 0);
    check("lw_br_fwd_d", hz.fwd_rs_d, 3);
    adv();
    nops(3);
    set_d(0, 0, 3, 3, 31, 0, 0);
    sample();
    adv();
    set_d(31, 0, 0, 3, 0, 3, 0);
    sample();
    check("jr_stall", hz.stall, 0);
    check("jr_fwd_d", hz.fwd_rs_d, 1);
    adv();
    nops(3);
    set_d(1, 2, 1, 1, 0, 1, 0);
    sample();
    adv();
    set_d(0, 0, 0, 0, 0, 3, 0);
    sample();
    check("zero_stall", hz.stall, 0);
    check("zero_fwd_rs", hz.fwd_rs_d, 0);
    check("zero_fwd_rt", hz.fwd_rt_d, 0);
    adv();
    nops(3);
    set_d(1, 2, 1, 1, 0, 3, 1);
    sample();
    adv();
    set_md(1, 0);
    set_d(0, 0, 3, 3, 2, 1, 1);
    sample();
    check("md_start_stall", hz.stall, 1);
    adv();
    set_md(0, 0);
    repeat (MULT_N) begin
      sample();
      check("md_hold_stall", hz.stall, 1);
      check("md_hold_busy", hz.md_busy, 1);
      adv();
    end
    sample();
    check("md_release", hz.stall, 0);
    check("md_done", hz.md_busy, 0);
    adv();
    nops(3);
    set_d(0, 0, 1, 3, 1, 2, 0);
    sample();
    adv();
    set_d(1, 0, 0, 0, 0, 3, 0);
    sample();
    adv();
    sample();
    check("rst_pre_stall", hz.stall, 1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_stall", hz.stall, 0);
    check("rst_fwd_rs_d", hz.fwd_rs_d, 0);
    check("rst_fwd_rt_d", hz.fwd_rt_d, 0);
    check("rst_fwd_e", {hz.fwd_rs_e, hz.fwd_rt_e, hz.fwd_rt_m}, 0);
    check("rst_md_busy", hz.md_busy, 0);
    adv();
    #1 rst_n = 1'b1;
    sample();
    check("rst_after_stall", hz.stall, 0);
    adv();
    sample();
    check("rst_after_stall2", hz.stall, 0);
    adv();
    for (int i = 0; i < 600; i++) begin
      if (!exp_stall())
        set_d($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5) == 0);
      set_md($urandom_range(0, 7) == 0, $urandom_range(0, 1));
      if (i == 300) begin
        #1 rst_n = 1'b0;
        model_reset();
        #1 rst_n = 1'b1;
      end
      sample();
      adv();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
